// File: rtl/mem_pkg.sv
// Shared definitions for the memory access initiator and the load/store unit:
// access sizes, initiator state codes and the load extension / store formatting helpers.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_SETUP    = 3'd2,
    S_STROBE   = 3'd3,
    S_WAIT_MOC = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_e;

  // Responder returns the addressed bytes right-justified, lower address in the upper byte.
  function automatic logic [31:0] extend(input logic [31:0] data, input logic [1:0] size,
                                         input logic sgn);
    case (size)
      SZ_BYTE: extend = {{24{sgn & data[7]}}, data[7:0]};
      SZ_HALF: extend = {{16{sgn & data[15]}}, data[15:0]};
      default: extend = data;
    endcase
  endfunction

  function automatic logic [31:0] store_format(input logic [31:0] data, input logic [1:0] size);
    case (size)
      SZ_BYTE: store_format = {24'b0, data[7:0]};
      SZ_HALF: store_format = {16'b0, data[15:0]};
      default: store_format = data;
    endcase
  endfunction

  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] addr_lsb);
    access_bad = (size == 2'd3) ||
                 ((size == SZ_HALF) && addr_lsb[0]) ||
                 ((size == SZ_WORD) && (addr_lsb != 2'b00));
  endfunction

endpackage

// File: rtl/moc_sync.sv
// Multi-flop synchronizer for the responder's asynchronous MOC handshake line.
module moc_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = async_in;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/mem_access_initiator.sv
// CPU-side initiator for the byte-lane RAM responder: one load/store at a time,
// Enable/MOC handshake with settle window and timeout, extended load data back to the datapath.
module mem_access_initiator
  import mem_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = 2,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [8:0]  addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_enable,
  output logic        mem_rw,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mode,
  input  logic        mem_moc,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] SETTLE_V   = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] TMO_LAST_V = CNT_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [8:0]        addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_rw_q, mem_rw_d;
  logic [8:0]        mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_mode_q, mem_mode_d;
  logic              moc_s;

  moc_sync #(.STAGES(SYNC_STAGES)) u_moc_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (mem_moc),
    .sync_out (moc_s)
  );

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    rw_d         = rw_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    mem_enable_d = mem_enable_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_mode_d   = mem_mode_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          rw_d    = rw;
          size_d  = size;
          sgn_d   = sgn;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (access_bad(size_q, addr_q[1:0])) begin
          state_d = S_ERR;
        end else begin
          // Bus fields are registered here so they are stable a full cycle before Enable rises.
          mem_addr_d  = addr_q;
          mem_rw_d    = rw_q;
          mem_mode_d  = {2'b00, size_q};
          mem_wdata_d = store_format(wdata_q, size_q);
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        mem_enable_d = 1'b1;
        wait_cnt_d   = '0;
        state_d      = S_STROBE;
      end
      S_STROBE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT_MOC;
      end
      S_WAIT_MOC: begin
        // Early synced MOC may be a leftover from the previous op, so it is not trusted yet.
        if ((wait_cnt_q >= SETTLE_V) && moc_s) begin
          mem_enable_d = 1'b0;
          state_d      = S_DONE;
          if (rw_q) begin
            rdata_d = extend(mem_rdata, size_q, sgn_q);
          end
        end else if (wait_cnt_q == TMO_LAST_V) begin
          mem_enable_d = 1'b0;
          state_d      = S_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      rw_q         <= 1'b1;
      size_q       <= 2'd0;
      sgn_q        <= 1'b0;
      addr_q       <= 9'd0;
      wdata_q      <= 32'd0;
      rdata_q      <= 32'd0;
      mem_enable_q <= 1'b0;
      mem_rw_q     <= 1'b1;
      mem_addr_q   <= 9'd0;
      mem_wdata_q  <= 32'd0;
      mem_mode_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      rw_q         <= rw_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      mem_enable_q <= mem_enable_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_mode_q   <= mem_mode_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE) || (state_q == S_ERR);
  assign err        = (state_q == S_ERR);
  assign rdata      = rdata_q;
  assign mem_enable = mem_enable_q;
  assign mem_rw     = mem_rw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_mode   = mem_mode_q;

endmodule
